// File: rtl/vga_fb_write_arbiter.sv
// Write-port arbiter for the VGA frame-buffer RAM: DMA bursts vs OSD beats.
// Optional stalled-burst timeout is enabled by defining ARB_TIMEOUT_EN.
module vga_fb_write_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 64,
    parameter int TIMEOUT   = 255
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              dma_valid,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_data,
    input  logic              dma_last,
    output logic              dma_ready,
    input  logic              osd_valid,
    input  logic [ADDR_W-1:0] osd_addr,
    input  logic [DATA_W-1:0] osd_data,
    output logic              osd_ready,
    output logic [ADDR_W-1:0] mem_wraddr,
    output logic              mem_wren,
    output logic [DATA_W-1:0] mem_wrdata,
    output logic [1:0]        owner,
    output logic              burst_active,
    output logic              err_timeout
);

    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_YLD = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_DMA  = 2'b01,
        S_OSD  = 2'b10
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] beat_cnt;
    logic             dma_acc;
    logic             osd_acc;
    logic             yield;
    logic             timeout_hit;

    assign dma_acc = dma_valid & dma_ready;
    assign osd_acc = osd_valid & osd_ready;

    // Hand one beat to OSD once the DMA has had its quota and OSD waits.
    assign yield = dma_acc & ~dma_last & osd_valid & (beat_cnt >= CNT_YLD);

    // State register.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: DMA wins ties, open bursts hold the port, OSD gets one beat.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (dma_valid) begin
                    state_nxt = S_DMA;
                end else if (osd_valid) begin
                    state_nxt = S_OSD;
                end
            end
            S_DMA: begin
                if (dma_acc) begin
                    if (dma_last) begin
                        state_nxt = osd_valid ? S_OSD : S_IDLE;
                    end else if (yield) begin
                        state_nxt = S_OSD;
                    end
                end else if (!burst_active) begin
                    state_nxt = S_IDLE;
                end else if (timeout_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            S_OSD: begin
                if (osd_acc) begin
                    state_nxt = (burst_active | dma_valid) ? S_DMA : S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Handshake and owner outputs decoded from state alone.
    always_comb begin
        dma_ready = (state == S_DMA);
        osd_ready = (state == S_OSD);
        owner     = state;
    end

    // Burst tracking and the saturating beat counter used for yielding.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            burst_active <= 1'b0;
            beat_cnt     <= '0;
        end else if (dma_acc) begin
            if (dma_last) begin
                burst_active <= 1'b0;
                beat_cnt     <= '0;
            end else begin
                burst_active <= 1'b1;
                if (yield) begin
                    beat_cnt <= '0;
                end else if (beat_cnt != CNT_MAX) begin
                    beat_cnt <= beat_cnt + CNT_W'(1);
                end
            end
        end else if (timeout_hit) begin
            burst_active <= 1'b0;
            beat_cnt     <= '0;
        end
    end

    // Registered RAM write port; address and data hold between writes.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            mem_wren   <= 1'b0;
            mem_wraddr <= '0;
            mem_wrdata <= '0;
        end else begin
            mem_wren <= dma_acc | osd_acc;
            if (dma_acc) begin
                mem_wraddr <= dma_addr;
                mem_wrdata <= dma_data;
            end else if (osd_acc) begin
                mem_wraddr <= osd_addr;
                mem_wrdata <= osd_data;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] stall_cnt;
    logic            stall;

    assign stall       = (state == S_DMA) & burst_active & ~dma_valid;
    assign timeout_hit = stall & (stall_cnt == TO_W'(TIMEOUT - 1));

    // Count idle cycles of an open burst; abandon it at the limit.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            stall_cnt   <= '0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= timeout_hit;
            if (stall & ~timeout_hit) begin
                stall_cnt <= stall_cnt + TO_W'(1);
            end else begin
                stall_cnt <= '0;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_vga_fb_write_arbiter.sv
// Randomized bench for vga_fb_write_arbiter with a cycle-level reference model.
// Directed scenarios pin the model with literal RAM write sequences.
module tb_vga_fb_write_arbiter;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int MB = 4;
    localparam int TO = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic          sysclk = 1'b0;
    logic          reset;
    logic          dma_valid;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_data;
    logic          dma_last;
    logic          dma_ready;
    logic          osd_valid;
    logic [AW-1:0] osd_addr;
    logic [DW-1:0] osd_data;
    logic          osd_ready;
    logic [AW-1:0] mem_wraddr;
    logic          mem_wren;
    logic [DW-1:0] mem_wrdata;
    logic [1:0]    owner;
    logic          burst_active;
    logic          err_timeout;

    int checks = 0;
    int errors = 0;

    // reference model state: who owns the port, burst open, beats since
    // burst start or last yield, idle cycles of an open burst
    logic [1:0]    m_own;
    logic          m_open;
    int            m_cnt;
    int            m_stall;
    logic          m_err;
    logic          m_wren;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic          m_dacc;
    logic          m_oacc;

    logic [1:0]    n_own;
    logic          n_open;
    int            n_cnt;
    int            n_stall;
    logic          n_err;
    logic          n_wren;
    logic [AW-1:0] n_addr;
    logic [DW-1:0] n_data;

    beat_t dq[$];
    beat_t oq[$];
    logic [AW+DW-1:0] wlog[$];
    logic [AW+DW-1:0] exp_log[$];
    logic dma_en;
    logic osd_en;

    always #5 sysclk = ~sysclk;

    vga_fb_write_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .MAX_BURST(MB),
        .TIMEOUT(TO)
    ) dut (
        .sysclk(sysclk),
        .reset(reset),
        .dma_valid(dma_valid),
        .dma_addr(dma_addr),
        .dma_data(dma_data),
        .dma_last(dma_last),
        .dma_ready(dma_ready),
        .osd_valid(osd_valid),
        .osd_addr(osd_addr),
        .osd_data(osd_data),
        .osd_ready(osd_ready),
        .mem_wraddr(mem_wraddr),
        .mem_wren(mem_wren),
        .mem_wrdata(mem_wrdata),
        .owner(owner),
        .burst_active(burst_active),
        .err_timeout(err_timeout)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_zero();
        m_own   = 2'd0;
        m_open  = 1'b0;
        m_cnt   = 0;
        m_stall = 0;
        m_err   = 1'b0;
        m_wren  = 1'b0;
        m_addr  = '0;
        m_data  = '0;
        m_dacc  = 1'b0;
        m_oacc  = 1'b0;
    endtask

    // arbitration rules applied to the inputs present this cycle
    task automatic model_next();
        m_dacc  = dma_valid && (m_own == 2'd1);
        m_oacc  = osd_valid && (m_own == 2'd2);
        n_own   = m_own;
        n_open  = m_open;
        n_cnt   = m_cnt;
        n_stall = m_stall;
        n_err   = 1'b0;
        n_wren  = m_dacc || m_oacc;
        n_addr  = m_addr;
        n_data  = m_data;
        if (m_dacc) begin
            n_addr = dma_addr;
            n_data = dma_data;
        end else if (m_oacc) begin
            n_addr = osd_addr;
            n_data = osd_data;
        end
        if (m_own == 2'd0) begin
            n_own = dma_valid ? 2'd1 : (osd_valid ? 2'd2 : 2'd0);
        end else if (m_own == 2'd1) begin
            if (m_dacc) begin
                n_stall = 0;
                if (dma_last) begin
                    n_open = 1'b0;
                    n_cnt  = 0;
                    n_own  = osd_valid ? 2'd2 : 2'd0;
                end else begin
                    n_open = 1'b1;
                    n_cnt  = m_cnt + 1;
                    if (n_cnt >= MB && osd_valid) begin
                        n_own = 2'd2;
                        n_cnt = 0;
                    end
                end
            end else if (m_open) begin
                n_stall = m_stall + 1;
                if (TO_ON && n_stall >= TO) begin
                    n_open  = 1'b0;
                    n_cnt   = 0;
                    n_own   = 2'd0;
                    n_err   = 1'b1;
                    n_stall = 0;
                end
            end else begin
                n_own = 2'd0;
            end
        end else if (m_oacc) begin
            n_own = (m_open || dma_valid) ? 2'd1 : 2'd0;
        end
    endtask

    task automatic compare();
        chk("owner", 32'(owner), 32'(m_own));
        chk("dma_ready", 32'(dma_ready), 32'(m_own == 2'd1));
        chk("osd_ready", 32'(osd_ready), 32'(m_own == 2'd2));
        chk("burst_active", 32'(burst_active), 32'(m_open));
        chk("err_timeout", 32'(err_timeout), 32'(m_err));
        chk("mem_wren", 32'(mem_wren), 32'(m_wren));
        chk("mem_wraddr", 32'(mem_wraddr), 32'(m_addr));
        chk("mem_wrdata", 32'(mem_wrdata), 32'(m_data));
    endtask

    task automatic step();
        model_next();
        @(posedge sysclk);
        #1;
        m_own   = n_own;
        m_open  = n_open;
        m_cnt   = n_cnt;
        m_stall = n_stall;
        m_err   = n_err;
        m_wren  = n_wren;
        m_addr  = n_addr;
        m_data  = n_data;
        compare();
        if (mem_wren) wlog.push_back({mem_wraddr, mem_wrdata});
    endtask

    task automatic drive_cycle();
        dma_valid = dma_en && (dq.size() > 0);
        dma_addr  = dma_valid ? dq[0].a : '0;
        dma_data  = dma_valid ? dq[0].d : '0;
        dma_last  = dma_valid ? dq[0].l : 1'b0;
        osd_valid = osd_en && (oq.size() > 0);
        osd_addr  = osd_valid ? oq[0].a : '0;
        osd_data  = osd_valid ? oq[0].d : '0;
        step();
        if (m_dacc) void'(dq.pop_front());
        if (m_oacc) void'(oq.pop_front());
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        dma_en = 1'b1;
        osd_en = 1'b1;
        while ((dq.size() > 0 || oq.size() > 0) && n < 500) begin
            drive_cycle();
            n++;
        end
        chk({nm, "_drained"}, 32'(dq.size() + oq.size()), 32'd0);
        repeat (2) drive_cycle();
    endtask

    task automatic chk_log(input string nm);
        chk({nm, "_count"}, 32'(wlog.size()), 32'(exp_log.size()));
        for (int i = 0; i < exp_log.size() && i < wlog.size(); i++) begin
            chk($sformatf("%s_w%0d", nm, i), 32'(wlog[i]), 32'(exp_log[i]));
        end
    endtask

    initial begin
        int stall_left;
        int n;
        reset     = 1'b0;
        dma_valid = 1'b0;
        dma_addr  = '0;
        dma_data  = '0;
        dma_last  = 1'b0;
        osd_valid = 1'b0;
        osd_addr  = '0;
        osd_data  = '0;
        dma_en    = 1'b0;
        osd_en    = 1'b0;
        model_zero();
        repeat (2) @(posedge sysclk);
        #1;
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_wren", 32'(mem_wren), 32'd0);
        chk("rst_addr", 32'(mem_wraddr), 32'd0);
        chk("rst_data", 32'(mem_wrdata), 32'd0);
        chk("rst_burst", 32'(burst_active), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        reset = 1'b1;
        repeat (3) drive_cycle();

        // 4-beat burst, OSD idle
        wlog.delete();
        for (int i = 0; i < 4; i++)
            dq.push_back('{a: AW'(i), d: DW'(8'hA0 + i), l: (i == 3)});
        drain("burst4");
        exp_log.delete();
        for (int i = 0; i < 4; i++)
            exp_log.push_back({AW'(i), DW'(8'hA0 + i)});
        chk_log("burst4");
        chk("burst4_owner", 32'(owner), 32'd0);

        // simultaneous request: DMA first, then the OSD beat
        wlog.delete();
        dq.push_back('{a: 16'h0100, d: 8'h11, l: 1'b1});
        oq.push_back('{a: 16'h1234, d: 8'h5A, l: 1'b0});
        dma_en = 1'b1;
        osd_en = 1'b1;
        drive_cycle();
        chk("tie_owner1", 32'(owner), 32'd1);
        drive_cycle();
        chk("tie_owner2", 32'(owner), 32'd2);
        drive_cycle();
        chk("tie_osd_addr", 32'(mem_wraddr), 32'h1234);
        chk("tie_osd_data", 32'(mem_wrdata), 32'h5A);
        drain("tie");
        exp_log.delete();
        exp_log.push_back({16'h0100, 8'h11});
        exp_log.push_back({16'h1234, 8'h5A});
        chk_log("tie");

        // 10-beat burst, OSD pending from beat 2: yields after 4 beats
        wlog.delete();
        for (int i = 0; i < 10; i++)
            dq.push_back('{a: AW'(16'h0200 + i), d: DW'(8'h40 + i), l: (i == 9)});
        oq.push_back('{a: 16'h0ABC, d: 8'h77, l: 1'b0});
        dma_en = 1'b1;
        n = 0;
        while (dq.size() > 0 && n < 200) begin
            osd_en = (dq.size() <= 9);
            drive_cycle();
            n++;
        end
        drain("yield");
        exp_log.delete();
        for (int i = 0; i < 4; i++)
            exp_log.push_back({AW'(16'h0200 + i), DW'(8'h40 + i)});
        exp_log.push_back({16'h0ABC, 8'h77});
        for (int i = 4; i < 10; i++)
            exp_log.push_back({AW'(16'h0200 + i), DW'(8'h40 + i)});
        chk_log("yield");

        // stalled open burst keeps the lock while OSD waits
        wlog.delete();
        for (int i = 0; i < 4; i++)
            dq.push_back('{a: AW'(16'h0300 + i), d: DW'(8'h50 + i), l: (i == 3)});
        oq.push_back('{a: 16'h0DEF, d: 8'h66, l: 1'b0});
        dma_en = 1'b1;
        osd_en = 1'b1;
        n = 0;
        while (dq.size() > 1 && n < 100) begin
            drive_cycle();
            n++;
        end
        dma_en = 1'b0;
        repeat (TO_ON ? 5 : 20) begin
            drive_cycle();
            chk("lock_owner", 32'(owner), 32'd1);
            chk("lock_osd_ready", 32'(osd_ready), 32'd0);
        end
        drain("lock");
        exp_log.delete();
        for (int i = 0; i < 4; i++)
            exp_log.push_back({AW'(16'h0300 + i), DW'(8'h50 + i)});
        exp_log.push_back({16'h0DEF, 8'h66});
        chk_log("lock");

        // long stall: timeout pulse when enabled, permanent lock otherwise
        wlog.delete();
        for (int i = 0; i < 3; i++)
            dq.push_back('{a: AW'(16'h0400 + i), d: DW'(8'h60 + i), l: (i == 2)});
        dma_en = 1'b1;
        osd_en = 1'b0;
        n = 0;
        while (dq.size() > 1 && n < 100) begin
            drive_cycle();
            n++;
        end
        dma_en = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            drive_cycle();
            chk($sformatf("to_err_k%0d", k), 32'(err_timeout),
                32'(TO_ON && k == TO));
            chk($sformatf("to_owner_k%0d", k), 32'(owner),
                (TO_ON && k >= TO) ? 32'd0 : 32'd1);
            chk($sformatf("to_burst_k%0d", k), 32'(burst_active),
                32'(!(TO_ON && k >= TO)));
        end
        drain("to");
        exp_log.delete();
        for (int i = 0; i < 3; i++)
            exp_log.push_back({AW'(16'h0400 + i), DW'(8'h60 + i)});
        chk_log("to");

        // reset asserted mid-burst at beat 10
        for (int i = 0; i < 20; i++)
            dq.push_back('{a: AW'(16'h0500 + i), d: DW'(i), l: (i == 19)});
        dma_en = 1'b1;
        osd_en = 1'b0;
        n = 0;
        while (dq.size() > 10 && n < 100) begin
            drive_cycle();
            n++;
        end
        chk("mid_burst_open", 32'(burst_active), 32'd1);
        reset = 1'b0;
        @(posedge sysclk);
        #1;
        chk("mrst_wren", 32'(mem_wren), 32'd0);
        chk("mrst_owner", 32'(owner), 32'd0);
        chk("mrst_burst", 32'(burst_active), 32'd0);
        model_zero();
        dq.delete();
        dma_en    = 1'b0;
        dma_valid = 1'b0;
        reset     = 1'b1;
        repeat (4) drive_cycle();
        chk("mrst_idle", 32'(owner), 32'd0);

        // randomized traffic
        stall_left = 0;
        for (int c = 0; c < 3000; c++) begin
            if (dq.size() == 0 && $urandom_range(0, 3) == 0) begin
                int len;
                logic [AW-1:0] base;
                len  = $urandom_range(1, 12);
                base = AW'($urandom);
                for (int i = 0; i < len; i++)
                    dq.push_back('{a: base + AW'(i), d: DW'($urandom),
                                   l: (i == len - 1)});
            end
            if (oq.size() == 0 && $urandom_range(0, 7) == 0)
                oq.push_back('{a: AW'($urandom), d: DW'($urandom), l: 1'b0});
            if (stall_left == 0 && $urandom_range(0, 39) == 0)
                stall_left = $urandom_range(5, 15);
            if (stall_left > 0) begin
                dma_en = 1'b0;
                stall_left--;
            end else begin
                dma_en = ($urandom_range(0, 9) < 8);
            end
            osd_en = ($urandom_range(0, 3) != 0);
            drive_cycle();
        end
        drain("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
